// File: rtl/riscv_cpu_pkg.sv
// riscv_cpu_pkg: shared types and constants for the hazard unit and its scoreboard
package riscv_cpu_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH = 32;
  localparam int SB_DEPTH = 3;
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  we;
    logic                  is_load;
  } sb_entry_t;
  typedef enum logic [1:0] {FWD_REG, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_e;
  typedef enum logic {RUN, STALL} hazard_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: three-entry EX->MEM->WB shift register of in-flight destinations
//   clk_i, rst_ni  clock, async active-low reset
//   id_entry_i     descriptor of the instruction leaving ID
//   bubble_ex_i    load a bubble into the EX entry instead of id_entry_i
//   flush_mem_i    load a bubble into the MEM entry instead of the EX entry
//   entries_o      [0]=EX, [1]=MEM, [2]=WB
module hazard_scoreboard
  import riscv_cpu_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  sb_entry_t                 id_entry_i,
  input  logic                      bubble_ex_i,
  input  logic                      flush_mem_i,
  output sb_entry_t [SB_DEPTH-1:0]  entries_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) entries_o <= '0;
    else begin
      entries_o[0] <= bubble_ex_i ? sb_entry_t'('0) : id_entry_i;
      entries_o[1] <= flush_mem_i ? sb_entry_t'('0) : entries_o[0];
      entries_o[2] <= entries_o[1];
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the five-stage pipeline
//   Inputs : clk_i, rst_ni (async active-low), ID descriptor (id_valid_i, id_rs1/2_i,
//            id_rs1/2_used_i, id_rd_i, id_reg_we_i, id_is_load_i), jal_op_i, branch_taken_i
//   Outputs: stall_if_o, stall_id_o, flush_if_o, flush_id_o, flush_ex_o,
//            fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
//   Build option: HAZARD_FORWARDING_EN enables operand forwarding (only load-use stalls);
//   otherwise full interlock against EX, MEM and WB with fwd_* tied to 0.
module hazard_unit
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_reg_we_i,
  input  logic                  id_is_load_i,
  input  logic                  jal_op_i,
  input  logic                  branch_taken_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  flush_if_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);
  sb_entry_t [SB_DEPTH-1:0] sb;
  sb_entry_t id_entry;
  hazard_state_e state_q, state_d;
  fwd_sel_e src_a, src_b;
  logic hazard, stall;
  function automatic logic hit(logic used, logic [ADDR_WIDTH-1:0] rs, sb_entry_t e);
    return used && rs != '0 && e.valid && e.we && rs == e.rd;
  endfunction
  // Youngest producer wins: EX before MEM before WB.
  function automatic fwd_sel_e youngest(logic used, logic [ADDR_WIDTH-1:0] rs, sb_entry_t [SB_DEPTH-1:0] e);
    return hit(used, rs, e[0]) ? FWD_EX : hit(used, rs, e[1]) ? FWD_MEM : hit(used, rs, e[2]) ? FWD_WB : FWD_REG;
  endfunction
  always_comb begin
    id_entry = '{valid: 1'b1, rd: id_rd_i, we: id_reg_we_i && id_rd_i != '0, is_load: id_is_load_i};
    src_a = youngest(id_valid_i && id_rs1_used_i, id_rs1_i, sb);
    src_b = youngest(id_valid_i && id_rs2_used_i, id_rs2_i, sb);
`ifdef HAZARD_FORWARDING_EN
    hazard = sb[0].is_load && (src_a == FWD_EX || src_b == FWD_EX);
    fwd_a_o = src_a;
    fwd_b_o = src_b;
`else
    hazard = src_a != FWD_REG || src_b != FWD_REG;
    fwd_a_o = 2'd0;
    fwd_b_o = 2'd0;
`endif
    stall = hazard && !branch_taken_i;
    stall_if_o = stall;
    stall_id_o = stall;
    flush_if_o = branch_taken_i || (jal_op_i && id_valid_i && !stall);
    flush_id_o = branch_taken_i || stall;
    flush_ex_o = branch_taken_i;
    state_d = stall ? STALL : RUN;
  end
  hazard_scoreboard u_sb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .id_entry_i  (id_entry),
    .bubble_ex_i (flush_id_o || !id_valid_i),
    .flush_mem_i (branch_taken_i),
    .entries_o   (sb)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= RUN;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == STALL && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_if_o && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against an in-bench pipeline model
module tb_hazard_unit;
  import riscv_cpu_pkg::*;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic id_valid_i, id_rs1_used_i, id_rs2_used_i, id_reg_we_i, id_is_load_i, jal_op_i, branch_taken_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic stall_if_o, stall_id_o, flush_if_o, flush_id_o, flush_ex_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  hazard_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i),
    .id_reg_we_i(id_reg_we_i), .id_is_load_i(id_is_load_i), .jal_op_i(jal_op_i),
    .branch_taken_i(branch_taken_i), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .flush_if_o(flush_if_o), .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {bit v; int rd; bit we; bit ld;} ent_t;
  ent_t pipe[3];
  ent_t empty;
  bit prev_stall;
  logic [31:0] scnt, fcnt;
  logic last_stall;
  logic [1:0] last_fa, last_fb;
  int vectors = 0, errors = 0;
  int n;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int a = 0; a < 3; a++) pipe[a] = empty;
    prev_stall = 0;
    scnt = 0;
    fcnt = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ":stall_if"}, 32'(stall_if_o), 0);
    chk({tag, ":stall_id"}, 32'(stall_id_o), 0);
    chk({tag, ":flush_if"}, 32'(flush_if_o), 0);
    chk({tag, ":flush_id"}, 32'(flush_id_o), 0);
    chk({tag, ":flush_ex"}, 32'(flush_ex_o), 0);
    chk({tag, ":fwd_a"}, 32'(fwd_a_o), 0);
    chk({tag, ":fwd_b"}, 32'(fwd_b_o), 0);
    chk({tag, ":stall_cnt"}, stall_cnt_o, 0);
    chk({tag, ":flush_cnt"}, flush_cnt_o, 0);
  endtask
  // Age of the youngest in-flight writer of rs (0=EX,1=MEM,2=WB), or -1.
  function automatic int first_hit(input logic used, input logic [4:0] rs);
    if (!used || rs == 0) return -1;
    for (int a = 0; a < 3; a++)
      if (pipe[a].v && pipe[a].we && pipe[a].rd == int'(rs)) return a;
    return -1;
  endfunction
  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                        input logic jal, input logic br);
    id_valid_i = v; id_rs1_i = r1; id_rs1_used_i = u1; id_rs2_i = r2; id_rs2_used_i = u2;
    id_rd_i = rd; id_reg_we_i = we; id_is_load_i = ld; jal_op_i = jal; branch_taken_i = br;
  endtask
  task automatic cycle(input string tag);
    int h1, h2, fa, fb;
    bit haz, st, fif, br, v;
    #1;
    v = id_valid_i;
    br = branch_taken_i;
    h1 = first_hit(v && id_rs1_used_i, id_rs1_i);
    h2 = first_hit(v && id_rs2_used_i, id_rs2_i);
`ifdef HAZARD_FORWARDING_EN
    haz = pipe[0].ld && (h1 == 0 || h2 == 0);
    fa = h1 + 1;
    fb = h2 + 1;
`else
    haz = h1 >= 0 || h2 >= 0;
    fa = 0;
    fb = 0;
`endif
    st = haz && !br;
    fif = br || (jal_op_i && v && !st);
    chk({tag, ":stall_if"}, 32'(stall_if_o), 32'(st));
    chk({tag, ":stall_id"}, 32'(stall_id_o), 32'(st));
    chk({tag, ":flush_if"}, 32'(flush_if_o), 32'(fif));
    chk({tag, ":flush_id"}, 32'(flush_id_o), 32'(br || st));
    chk({tag, ":flush_ex"}, 32'(flush_ex_o), 32'(br));
    chk({tag, ":fwd_a"}, 32'(fwd_a_o), 32'(fa));
    chk({tag, ":fwd_b"}, 32'(fwd_b_o), 32'(fb));
    chk({tag, ":stall_cnt"}, stall_cnt_o, scnt);
    chk({tag, ":flush_cnt"}, flush_cnt_o, fcnt);
    last_stall = stall_id_o;
    last_fa = fwd_a_o;
    last_fb = fwd_b_o;
    if (prev_stall && scnt != 32'hFFFF_FFFF) scnt++;
    prev_stall = st;
    if (fif && fcnt != 32'hFFFF_FFFF) fcnt++;
    pipe[2] = pipe[1];
    pipe[1] = br ? empty : pipe[0];
    pipe[0] = (br || st || !v) ? empty : '{v: 1'b1, rd: int'(id_rd_i), we: id_reg_we_i && id_rd_i != 0, ld: id_is_load_i};
    @(posedge clk_i);
    #1;
  endtask
  // Hold the current ID instruction until it issues; cnt = stall cycles seen.
  task automatic issue(input string tag, output int cnt);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(tag);
      if (!last_stall) return;
      cnt++;
    end
    vectors++;
    errors++;
    $error("FAIL %s:timeout observed stall after %0d cycles expected issue", tag, cnt);
  endtask
  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle("drain");
  endtask
  initial begin
    empty = '{v: 0, rd: 0, we: 0, ld: 0};
    model_reset();
    last_stall = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #7;
    chk_zero("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    // addi x5,x0,1 ; add x6,x5,x5
    set_id(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    cycle("b2b.prod");
    set_id(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    issue("b2b.cons", n);
`ifdef HAZARD_FORWARDING_EN
    chk("b2b.len", n, 0);
    chk("b2b.fwd_a", 32'(last_fa), 1);
    chk("b2b.fwd_b", 32'(last_fb), 1);
    chk("b2b.cnt", stall_cnt_o, 0);
`else
    chk("b2b.len", n, 3);
    chk("b2b.cnt", stall_cnt_o, 3);
`endif
    drain();
    // lw x7,0(x1) ; add x8,x7,x1
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    cycle("lu.prod");
    set_id(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
    issue("lu.cons", n);
`ifdef HAZARD_FORWARDING_EN
    chk("lu.len", n, 1);
    chk("lu.fwd_a", 32'(last_fa), 2);
    chk("lu.fwd_b", 32'(last_fb), 0);
`else
    chk("lu.len", n, 3);
`endif
    drain();
    // x0 producer then x0 consumer; unused rs2 matching a pending rd
    set_id(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    cycle("x0.prod");
    set_id(1, 0, 1, 0, 1, 9, 1, 1, 0, 0);
    cycle("x0.cons");
    chk("x0.stall", 32'(last_stall), 0);
    set_id(1, 3, 1, 9, 0, 4, 1, 0, 0, 0);
    cycle("unused.cons");
    chk("unused.stall", 32'(last_stall), 0);
    drain();
    // branch taken while stalled on a load
    set_id(1, 1, 1, 0, 0, 10, 1, 1, 0, 0);
    cycle("bds.prod");
    set_id(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
    cycle("bds.stall");
    chk("bds.stall", 32'(last_stall), 1);
    branch_taken_i = 1;
    cycle("bds.br");
    chk("bds.br_stall", 32'(last_stall), 0);
    branch_taken_i = 0;
    cycle("bds.after");
    drain();
    // branch squashes the younger EX entry: x12 never reaches WB
    set_id(1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    cycle("sq.prod");
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle("sq.br");
    set_id(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
    cycle("sq.cons");
    chk("sq.stall", 32'(last_stall), 0);
    chk("sq.fwd_a", 32'(last_fa), 0);
    drain();
    // jal x1 ; add x2,x1,x0
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    cycle("jal");
    set_id(1, 1, 1, 0, 1, 2, 1, 0, 0, 0);
    cycle("jal.next");
`ifdef HAZARD_FORWARDING_EN
    chk("jal.fwd_a", 32'(last_fa), 1);
`else
    chk("jal.stall", 32'(last_stall), 1);
`endif
    drain();
    // randomized traffic; a stalled instruction is held in ID
    for (int i = 0; i < 400; i++) begin
      if (!last_stall)
        set_id(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 0);
      branch_taken_i = 1'($urandom_range(0, 11) == 0);
      cycle("rand");
    end
    drain();
    // reset while the scoreboard is full and the FSM is in STALL
    set_id(1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    cycle("rst.p1");
    set_id(1, 0, 0, 0, 0, 15, 1, 0, 0, 0);
    cycle("rst.p2");
    set_id(1, 0, 0, 0, 0, 16, 1, 1, 0, 0);
    cycle("rst.p3");
    set_id(1, 16, 1, 14, 1, 17, 1, 0, 0, 0);
    cycle("rst.stall");
    chk("rst.stall", 32'(last_stall), 1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_zero("rst.async");
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycle("rst.first");
    chk("rst.first_stall", 32'(last_stall), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline controller for the five-stage core.
- Tracks destination registers in flight in EX, MEM and WB with a three-entry scoreboard.
- Compares them against the source registers of the instruction in ID, then drives stall, flush and operand-forwarding controls.
- Sits beside `id_stage`: it holds IF/ID on data hazards, bubbles ID→EX, and squashes wrong-path work on `jal` and taken branches.

## Interface
- `ADDR_WIDTH`, 5, register index width (package constant).
- `CNT_WIDTH`, 32, width of the performance counters.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `id_valid_i`  in  1  ID holds a real instruction.
- `id_rs1_i`, `id_rs2_i`  in  ADDR_WIDTH each  source register indices.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1 each  source actually read.
- `id_rd_i`  in  ADDR_WIDTH  destination index.
- `id_reg_we_i`  in  1  instruction writes rd.
- `id_is_load_i`  in  1  instruction is a load.
- `jal_op_i`  in  1  `jal` decoded in ID (same signal as ID's `jal_op_o`).
- `branch_taken_i`  in  1  branch resolved taken in MEM.
- `stall_if_o`, `stall_id_o`  out  1 each  hold PC and the IF/ID register.
- `flush_if_o`  out  1  kill the IF/ID register contents.
- `flush_id_o`  out  1  load a bubble into ID/EX.
- `flush_ex_o`  out  1  load a bubble into EX/MEM.
- `fwd_a_o`, `fwd_b_o`  out  2 each  operand source select.
- `stall_cnt_o`, `flush_cnt_o`  out  CNT_WIDTH each  saturating event counters.

## Operation
- Scoreboard entry fields: `{valid, rd, we, is_load}`.
  - `we` is forced to 0 when rd = 0.
- Scoreboard update each clock (EX → MEM → WB shift):
  - WB ← MEM.
  - MEM ← EX, or a bubble if `branch_taken_i`.
  - EX ← ID descriptor, or a bubble if `stall_id_o`, `flush_id_o` or `!id_valid_i`.
- Match definition: source used, rs ≠ 0, entry valid, entry `we` set, rs = entry rd.
- Hazard with `FORWARDING_EN` defined:
  - Stall only on a match against the EX entry when that entry has `is_load` set (load-use).
- Hazard without `FORWARDING_EN`:
  - Stall on a match against any of EX, MEM or WB.
  - The register file is not write-through, so a WB match also stalls.
- Stall:
  - `stall_if_o` = `stall_id_o` = 1.
  - `flush_id_o` = 1, so a bubble enters EX.
- Branch taken:
  - `flush_if_o` = `flush_id_o` = `flush_ex_o` = 1.
  - Stall is forced to 0.
  - The younger EX scoreboard entry becomes a bubble in MEM.
- `jal_op_i` with `id_valid_i` and no stall:
  - `flush_if_o` = 1 for one cycle.
  - The `jal` itself enters the scoreboard normally, since it writes rd.
- Priority: `branch_taken_i` > stall > `jal_op_i`.
- FSM `hazard_state_e`:
  - States: RUN, STALL.
  - RUN→STALL when a hazard is detected.
  - STALL→RUN when the hazard clears or `branch_taken_i` is asserted.
  - The state register is used for event counting: `stall_cnt_o` increments in every STALL cycle.
- `flush_cnt_o` increments once per cycle in which `branch_taken_i` is asserted or `flush_if_o` is driven.
- Both counters saturate at all-ones.

## Timing
- `stall_*`, `flush_*` and `fwd_*` are combinational from ID inputs and scoreboard registers, in the same cycle.
- The scoreboard, FSM and counters update on `posedge clk_i`.
- Reset: all entries invalid, state RUN, counters 0.
  - All outputs are therefore 0 until ID inputs change.
- Reset asserted mid-stall clears the scoreboard immediately; the stall drops asynchronously.
- Stall length:
  - With forwarding: load-use costs 1 cycle.
  - Without forwarding: producer in EX costs 3 cycles, in MEM 2 cycles, in WB 1 cycle.
- Both sources hazarded: the stall lasts until the longer of the two clears.
- `branch_taken_i` during a stall: the flush happens in that cycle, and the stall ends.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - `fwd_a_o`/`fwd_b_o` select the operand source: 0 = regfile, 1 = EX ALU result, 2 = MEM result, 3 = WB data.
  - The youngest match wins.
  - Only load-use hazards stall.
- `HAZARD_FORWARDING_EN` undefined:
  - `fwd_a_o`/`fwd_b_o` are tied to 0.
  - Full interlock against all three entries.

## Structure
- `riscv_cpu_pkg` additions:
  - `sb_entry_t`.
  - `fwd_sel_e` (FWD_REG, FWD_EX, FWD_MEM, FWD_WB).
  - `hazard_state_e`.
  - `SB_DEPTH = 3`.
- One sub-module, `hazard_scoreboard`:
  - Contains the three-entry shift register with bubble/flush inputs.
  - Exposes the entries as an array.
- `hazard_unit` contains the match logic, priority logic, FSM and counters.

## Test plan
- **Back-to-back dependency.** `addi x5` followed by `add x6,x5,x5`.
  - No forwarding: stall 3 cycles, `stall_cnt_o` = 3.
  - With forwarding: no stall, `fwd_a_o` = `fwd_b_o` = 1.
- **Load-use, forwarding on.** `lw x7`, then `add x8,x7,x1`.
  - 1-cycle stall, then `fwd_a_o` = 2, `fwd_b_o` = 0.
- **x0 and unused sources.** rd = 0 producer followed by a consumer reading x0; consumer with `rs2_used` = 0 matching a pending rd.
  - No stall in any configuration.
- **Branch during stall.** Assert `branch_taken_i` while in STALL.
  - Same cycle: `flush_if/id/ex` = 1, `stall_id_o` = 0.
  - Next cycle: the EX entry becomes a bubble in MEM, and the FSM is in RUN.
- **jal redirect.** `jal x1` in ID, no hazard.
  - `flush_if_o` = 1 for exactly 1 cycle.
  - A later `add x2,x1,x0` sees x1 pending.
- **Reset mid-operation.** Assert `rst_ni` low with the scoreboard full and the FSM in STALL.
  - All outputs 0 asynchronously.
  - After release, counters read 0 and the first instruction issues without a stall.
